pending_txn_tracker: RTL and testbench

Parametrised successor to the NIC's on-the-fly pending-transaction table. It records every request the node→NoC path launches and answers hit/miss queries from the NoC→node path. It retires matching entries on completion. New behaviour over the previous table: configurable depth, a full/backpressure flag, an occupancy count, per-entry age timeout with expiry reporting, and a sticky overflow error. It sits between wb2noc (inserts) and noc2wb (queries/deletes) inside the NIC.

---
 rtl/pending_txn_tracker_pkg.sv | 14 +
 rtl/pending_txn_tracker_ptt_entry.sv | 62 ++++++
 rtl/pending_txn_tracker.sv | 132 +++++++++++++
 tb/tb_pending_txn_tracker.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pending_txn_tracker_pkg.sv
// Shared defaults and helpers for the pending-transaction tracker.
package pending_txn_tracker_pkg;

  // Default field widths, matching the NIC head-flit field sizes.
  localparam int PTT_SRC_W  = 4;
  localparam int PTT_DEST_W = 4;
  localparam int PTT_CMD_W  = 2;

  // Age counter width; at least one bit even when the timeout is disabled.
  function automatic int ptt_age_w(input int timeout_cycles);
    return (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;
  endfunction

endpackage

// File: rtl/pending_txn_tracker_ptt_entry.sv
// One table slot: valid bit, stored fields, saturating age counter,
// match comparator and expiry flag.
module ptt_entry
  import pending_txn_tracker_pkg::*;
#(
  parameter int SRC_W          = PTT_SRC_W,
  parameter int DEST_W         = PTT_DEST_W,
  parameter int CMD_W          = PTT_CMD_W,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int AGE_W          = ptt_age_w(TIMEOUT_CYCLES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ins,
  input  logic              clr,
  input  logic [SRC_W-1:0]  new_src,
  input  logic [DEST_W-1:0] new_dst,
  input  logic [CMD_W-1:0]  new_cmd,
  input  logic [SRC_W-1:0]  q_src,
  input  logic [DEST_W-1:0] q_dst,
  input  logic [CMD_W-1:0]  q_cmd,
  output logic              valid,
  output logic [SRC_W-1:0]  src,
  output logic [DEST_W-1:0] dst,
  output logic [CMD_W-1:0]  cmd,
  output logic              match,
  output logic              expire
);

  localparam logic [AGE_W-1:0] LIM    = AGE_W'(TIMEOUT_CYCLES);
  // Age is one below the limit on the edge where the entry expires, so an
  // entry inserted at edge t is cleared at edge t+TIMEOUT_CYCLES.
  localparam logic [AGE_W-1:0] LIM_M1 = (TIMEOUT_CYCLES > 0) ? AGE_W'(TIMEOUT_CYCLES - 1) : '0;

  logic [AGE_W-1:0] age;

  assign match  = valid && (src == q_src) && (dst == q_dst) && (cmd == q_cmd);
  assign expire = (TIMEOUT_CYCLES != 0) && valid && (age >= LIM_M1);

  // Slot state: insert loads fields, clear retires, age saturates at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      age   <= '0;
      src   <= '0;
      dst   <= '0;
      cmd   <= '0;
    end else if (ins) begin
      valid <= 1'b1;
      age   <= '0;
      src   <= new_src;
      dst   <= new_dst;
      cmd   <= new_cmd;
    end else if (clr) begin
      valid <= 1'b0;
      age   <= '0;
    end else if (valid && age != LIM) begin
      age   <= age + 1'b1;
    end
  end

endmodule

// File: rtl/pending_txn_tracker.sv
// Pending-transaction table: inserts from wb2noc, hit queries and retires
// from noc2wb, age timeout with one expiry report per cycle.
module pending_txn_tracker
  import pending_txn_tracker_pkg::*;
#(
  parameter int DEPTH          = 8,
  parameter int SRC_W          = PTT_SRC_W,
  parameter int DEST_W         = PTT_DEST_W,
  parameter int CMD_W          = PTT_CMD_W,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int AGE_W          = ptt_age_w(TIMEOUT_CYCLES),
  parameter int CNT_W          = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              new_pending_transaction_i,
  input  logic [SRC_W-1:0]  new_sender_i,
  input  logic [DEST_W-1:0] new_recipient_i,
  input  logic [CMD_W-1:0]  new_transaction_type_i,
  output logic              table_full_o,
  input  logic              query_i,
  input  logic [SRC_W-1:0]  query_sender_i,
  input  logic [DEST_W-1:0] query_recipient_i,
  input  logic [CMD_W-1:0]  query_transaction_type_i,
  output logic              is_a_pending_transaction_o,
  input  logic              delete_transaction_i,
  output logic [CNT_W-1:0]  occupancy_o,
  output logic              timeout_o,
  output logic [SRC_W-1:0]  timeout_sender_o,
  output logic [DEST_W-1:0] timeout_recipient_o,
  output logic [CMD_W-1:0]  timeout_transaction_type_o,
  output logic              overflow_o
);

  logic [DEPTH-1:0]             valid, match, expire;
  logic [DEPTH-1:0]             free_oh, del_oh, exp_oh;
  logic [DEPTH-1:0][SRC_W-1:0]  ent_src;
  logic [DEPTH-1:0][DEST_W-1:0] ent_dst;
  logic [DEPTH-1:0][CMD_W-1:0]  ent_cmd;
  logic [SRC_W-1:0]             sel_src;
  logic [DEST_W-1:0]            sel_dst;
  logic [CMD_W-1:0]             sel_cmd;
  logic                         ins_ok, do_del;

  // Fullness is taken from registered state, so inserts see the table as it
  // stood before this edge even if a delete or expiry frees a slot now.
  assign ins_ok = new_pending_transaction_i && !table_full_o;
  assign is_a_pending_transaction_o = query_i && (|match);
  assign do_del = delete_transaction_i && is_a_pending_transaction_o;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    ptt_entry #(
      .SRC_W(SRC_W), .DEST_W(DEST_W), .CMD_W(CMD_W),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .AGE_W(AGE_W)
    ) u_ent (
      .clk(clk), .rst(rst),
      .ins(free_oh[i] && ins_ok),
      .clr(del_oh[i] || exp_oh[i]),
      .new_src(new_sender_i), .new_dst(new_recipient_i), .new_cmd(new_transaction_type_i),
      .q_src(query_sender_i), .q_dst(query_recipient_i), .q_cmd(query_transaction_type_i),
      .valid(valid[i]), .src(ent_src[i]), .dst(ent_dst[i]), .cmd(ent_cmd[i]),
      .match(match[i]), .expire(expire[i])
    );
  end

  // Lowest free slot for inserts.
  always_comb begin
    logic found;
    found   = 1'b0;
    free_oh = '0;
    for (int i = 0; i < DEPTH; i++)
      if (!valid[i] && !found) begin free_oh[i] = 1'b1; found = 1'b1; end
  end

  // Lowest matching slot for deletes.
  always_comb begin
    logic found;
    found  = 1'b0;
    del_oh = '0;
    for (int i = 0; i < DEPTH; i++)
      if (do_del && match[i] && !found) begin del_oh[i] = 1'b1; found = 1'b1; end
  end

  // Expiry arbiter: lowest expiring slot not being deleted this cycle.
  always_comb begin
    logic found;
    found  = 1'b0;
    exp_oh = '0;
    for (int i = 0; i < DEPTH; i++)
      if (expire[i] && !del_oh[i] && !found) begin exp_oh[i] = 1'b1; found = 1'b1; end
  end

  // Field mux for the reported entry (exp_oh is one-hot or zero).
  always_comb begin
    sel_src = '0;
    sel_dst = '0;
    sel_cmd = '0;
    for (int i = 0; i < DEPTH; i++)
      if (exp_oh[i]) begin
        sel_src = sel_src | ent_src[i];
        sel_dst = sel_dst | ent_dst[i];
        sel_cmd = sel_cmd | ent_cmd[i];
      end
  end

  // Occupancy is the popcount of the valid bits.
  always_comb begin
    occupancy_o = '0;
    for (int i = 0; i < DEPTH; i++)
      occupancy_o = occupancy_o + CNT_W'(valid[i]);
  end

  assign table_full_o = (occupancy_o == CNT_W'(DEPTH));

  // Registered expiry report and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_o                  <= 1'b0;
      timeout_sender_o           <= '0;
      timeout_recipient_o        <= '0;
      timeout_transaction_type_o <= '0;
      overflow_o                 <= 1'b0;
    end else begin
      timeout_o                  <= |exp_oh;
      timeout_sender_o           <= sel_src;
      timeout_recipient_o        <= sel_dst;
      timeout_transaction_type_o <= sel_cmd;
      overflow_o                 <= overflow_o || (new_pending_transaction_i && table_full_o);
    end
  end

endmodule

// File: tb/tb_pending_txn_tracker.sv
// Directed bench for pending_txn_tracker (DEPTH=4, TIMEOUT_CYCLES=16).
module tb_pending_txn_tracker;

  localparam int DEPTH = 4;
  localparam int TO    = 16;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             new_p;
  logic [3:0]       n_src, n_dst;
  logic [1:0]       n_cmd;
  logic             full;
  logic             query;
  logic [3:0]       q_src, q_dst;
  logic [1:0]       q_cmd;
  logic             hit;
  logic             del;
  logic [CNT_W-1:0] occ;
  logic             tout;
  logic [3:0]       t_src, t_dst;
  logic [1:0]       t_cmd;
  logic             ovf;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pending_txn_tracker #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .new_pending_transaction_i(new_p), .new_sender_i(n_src),
    .new_recipient_i(n_dst), .new_transaction_type_i(n_cmd),
    .table_full_o(full),
    .query_i(query), .query_sender_i(q_src), .query_recipient_i(q_dst),
    .query_transaction_type_i(q_cmd),
    .is_a_pending_transaction_o(hit),
    .delete_transaction_i(del),
    .occupancy_o(occ),
    .timeout_o(tout), .timeout_sender_o(t_src), .timeout_recipient_o(t_dst),
    .timeout_transaction_type_o(t_cmd),
    .overflow_o(ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    new_p = 0; query = 0; del = 0;
    n_src = 0; n_dst = 0; n_cmd = 0;
    q_src = 0; q_dst = 0; q_cmd = 0;
  endtask

  task automatic ins(input logic [3:0] s, input logic [3:0] d, input logic [1:0] c);
    new_p = 1; n_src = s; n_dst = d; n_cmd = c;
  endtask

  task automatic qry(input logic [3:0] s, input logic [3:0] d, input logic [1:0] c, input logic dl);
    query = 1; q_src = s; q_dst = d; q_cmd = c; del = dl;
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
  endtask

  initial begin
    idle();
    rst = 1;
    tick(); tick();
    rst = 0;

    // Reset state
    chk("rst_occ", occ, 0);
    chk("rst_full", full, 0);
    chk("rst_tout", tout, 0);
    chk("rst_tfields", {t_src, t_dst, t_cmd}, 0);
    chk("rst_ovf", ovf, 0);
    qry(1, 2, 0, 0);
    chk("rst_hit", hit, 0);
    idle();

    // Fill to full
    ins(1, 2, 0); tick(); chk("fill_occ1", occ, 1);
    ins(3, 4, 1); tick(); chk("fill_occ2", occ, 2);
    ins(5, 6, 2); tick(); chk("fill_occ3", occ, 3); chk("fill_nfull3", full, 0);
    ins(7, 8, 3); tick(); chk("fill_occ4", occ, 4); chk("fill_full", full, 1);
    idle();

    // Insert of new txn plus delete of (1,2,0) while full: insert rejected
    ins(11, 12, 3);
    qry(1, 2, 0, 1);
    chk("full_del_hit", hit, 1);
    tick(); idle();
    chk("full_insdel_occ", occ, 3);
    chk("full_insdel_nfull", full, 0);
    chk("full_insdel_ovf", ovf, 1);
    qry(11, 12, 3, 0); chk("rejected_miss", hit, 0);
    qry(1, 2, 0, 0);   chk("deleted_miss", hit, 0);
    idle();

    // Hit / delete (3,4,1)
    qry(3, 4, 1, 0); chk("q341_hit", hit, 1);
    qry(3, 4, 2, 0); chk("q342_miss", hit, 0);
    qry(3, 4, 1, 1); tick(); idle();
    chk("del341_occ", occ, 2);
    qry(3, 4, 1, 0); chk("del341_miss", hit, 0);
    qry(5, 6, 2, 0); chk("q562_hit", hit, 1);
    idle();
    // Delete on a miss is ignored
    qry(9, 9, 1, 1); tick(); idle();
    chk("delmiss_occ", occ, 2);
    chk("ovf_sticky", ovf, 1);

    // Reset mid-operation with 3 entries
    ins(13, 14, 1); tick(); idle();
    chk("pre_rst_occ", occ, 3);
    do_reset();
    chk("mrst_occ", occ, 0);
    chk("mrst_full", full, 0);
    chk("mrst_ovf", ovf, 0);
    chk("mrst_tout", tout, 0);
    qry(7, 8, 3, 0); chk("mrst_miss", hit, 0);
    idle();

    // Duplicates
    ins(1, 1, 1); tick();
    ins(1, 1, 1); tick(); idle();
    chk("dup_occ2", occ, 2);
    qry(1, 1, 1, 1); tick(); idle();
    chk("dup_occ1", occ, 1);
    qry(1, 1, 1, 0); chk("dup_still_hit", hit, 1);
    qry(1, 1, 1, 1); tick(); idle();
    chk("dup_occ0", occ, 0);
    qry(1, 1, 1, 0); chk("dup_miss", hit, 0);
    idle();

    // Timeout: insert at edge t, pulse after edge t+16
    begin
      int early = 0;
      ins(9, 10, 2); tick(); idle();
      for (int i = 1; i < TO; i++) begin
        tick();
        if (tout) early++;
      end
      chk("to_no_early", early, 0);
      chk("to_occ_before", occ, 1);
      tick();
      chk("to_pulse", tout, 1);
      chk("to_fields", {t_src, t_dst, t_cmd}, {4'd9, 4'd10, 2'd2});
      chk("to_occ_after", occ, 0);
      tick();
      chk("to_one_cycle", tout, 0);
    end

    // Delete on the expiry edge wins: no pulse
    begin
      int early = 0;
      ins(9, 10, 2); tick(); idle();
      for (int i = 1; i < TO; i++) begin
        tick();
        if (tout) early++;
      end
      qry(9, 10, 2, 1); tick(); idle();
      chk("delwin_no_pulse", tout | (early != 0), 0);
      chk("delwin_occ", occ, 0);
    end

    // Two expiries on consecutive edges reported in index order
    begin
      int early = 0;
      ins(1, 3, 0); tick();
      ins(2, 4, 1); tick(); idle();
      for (int i = 2; i < TO; i++) begin
        tick();
        if (tout) early++;
      end
      chk("seq_no_early", early, 0);
      tick();
      chk("seq_p1", tout, 1);
      chk("seq_p1_fields", {t_src, t_dst, t_cmd}, {4'd1, 4'd3, 2'd0});
      chk("seq_p1_occ", occ, 1);
      tick();
      chk("seq_p2", tout, 1);
      chk("seq_p2_fields", {t_src, t_dst, t_cmd}, {4'd2, 4'd4, 2'd1});
      chk("seq_p2_occ", occ, 0);
      tick();
      chk("seq_done", tout, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
